// File: rtl/regs_wb_ctrl.sv
// Register-file write-back controller: merges in-order pipeline results with buffered
// long-latency results and tracks pending long-latency destinations for decode stalls.
module regs_wb_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      p_valid,
    output logic                      p_ready,
    input  logic [REG_ADDR_WIDTH-1:0] p_waddr,
    input  logic [REG_DATA_WIDTH-1:0] p_wdata,
    input  logic                      l_valid,
    output logic                      l_ready,
    input  logic [REG_ADDR_WIDTH-1:0] l_waddr,
    input  logic [REG_DATA_WIDTH-1:0] l_wdata,
    input  logic                      claim_valid,
    input  logic [REG_ADDR_WIDTH-1:0] claim_addr,
    input  logic [REG_ADDR_WIDTH-1:0] q_addr1,
    input  logic [REG_ADDR_WIDTH-1:0] q_addr2,
    output logic                      q_busy1,
    output logic                      q_busy2,
    output logic                      we,
    output logic [REG_ADDR_WIDTH-1:0] waddr,
    output logic [REG_DATA_WIDTH-1:0] wdata,
    output logic                      err
);

    localparam int REG_NUM = 1 << REG_ADDR_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [REG_DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_PIPE,
        SEL_FIFO
    } sel_e;

    entry_t               fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [REG_NUM-1:0]   pending_q, pending_d;
    logic                 err_q, err_d;
    logic                 we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;

    sel_e   sel;
    entry_t head;
    entry_t chosen;
    logic   full;
    logic   enq;
    logic   deq;
    logic   clear_hit;

    assign head    = fifo_q[rd_ptr_q];
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign l_ready = !full;
    assign enq     = l_valid && l_ready;
    assign q_busy1 = pending_q[q_addr1];
    assign q_busy2 = pending_q[q_addr2];
    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign err     = err_q;

    // NOTE: always_comb gives every output a default first, so no path can infer a latch.
    always_comb begin
        sel     = SEL_IDLE;
        p_ready = 1'b0;
        chosen  = '0;
        if (full) begin
            sel = SEL_FIFO;
        end else if (p_valid) begin
            sel     = SEL_PIPE;
            p_ready = 1'b1;
        end else if (count_q != '0) begin
            sel = SEL_FIFO;
        end

        if (sel == SEL_FIFO) begin
            chosen = head;
        end else if (sel == SEL_PIPE) begin
            chosen.addr = p_waddr;
            chosen.data = p_wdata;
        end
        deq = (sel == SEL_FIFO);

        we_d    = (sel != SEL_IDLE) && (chosen.addr != '0);
        waddr_d = chosen.addr;
        wdata_d = chosen.data;

        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
        end

        // Clear comes first so a same-edge claim of the retiring register re-sets it.
        clear_hit = deq && (head.addr == claim_addr);
        pending_d = pending_q;
        if (deq) begin
            pending_d[head.addr] = 1'b0;
        end
        err_d = err_q;
        if (claim_valid && (claim_addr != '0)) begin
            pending_d[claim_addr] = 1'b1;
            if (pending_q[claim_addr] && !clear_hit) begin
                err_d = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    // NOTE: the buffer storage is not reset; an entry is only read after count says it was written.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            fifo_q[wr_ptr_q] <= '{addr: l_waddr, data: l_wdata};
        end
    end

endmodule
